host_insn_bridge: RTL
=====================

Name: host_insn_bridge

Overview:
- Sits inside FPGATop, directly downstream of the host wire-in endpoints for the instruction path: wire-in 0x04 (bits_0), wire-in 0x05 (bits_1) and wire-in 0x03 (valid level).
- Converts the host's level-toggled "valid" into single enqueue events.
- Assembles the two 32-bit words into a 64-bit instruction, buffers it in a small FIFO, and presents it to the emulator core as a ready/valid (decoupled) stream.
- Drives the insns_ready wire-out (0x20) and status counters back to the host.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, 16, width of enq_count and drop_count.

Ports:
- clock  in  1  single design clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- wi_bits_0  in  32  instruction low word (wire-in 0x04).
- wi_bits_1  in  32  instruction high word (wire-in 0x05).
- wi_valid  in  1  host valid level; only bit 0 of wire-in 0x03 is used.
- wo_insns_ready  out  1  host-visible ready (wire-out 0x20); 1 when FIFO not full.
- deq_valid  out  1  FIFO head valid toward the core.
- deq_ready  in  1  core accepts the head.
- deq_bits  out  64  {wi_bits_1, wi_bits_0} of the head entry.
- occupancy  out  log2(DEPTH)+1  current entry count.
- enq_count  out  CNT_W  accepted instructions; wraps modulo 2^CNT_W.
- drop_count  out  CNT_W  edges rejected because the FIFO was full; saturates at all-ones.

Behaviour:
- Reset values: occupancy=0, deq_valid=0, wo_insns_ready=1, enq_count=0, drop_count=0, FIFO pointers=0. valid_q (previous-cycle wi_valid) resets to 1.
- Because valid_q resets to 1, a wi_valid held high across reset does not enqueue; the host must drive 0 then 1.
- Edge detect: edge = wi_valid & ~valid_q. valid_q <= wi_valid every cycle.
- Capture: on the edge cycle, {wi_bits_1, wi_bits_0} is sampled combinationally in that same cycle. The words must already be stable, as the host writes them with earlier UpdateWireIns.
- Accept condition: edge & (~full | (deq_valid & deq_ready)).
  - Accepted: write the entry at wr_ptr, increment wr_ptr (wraps at DEPTH), increment enq_count.
  - Not accepted: increment drop_count (saturating). FIFO contents unchanged.
- Latency: edge sampled in cycle N -> entry visible at the head with deq_valid=1 in cycle N+1. There is no combinational path from the wi_* inputs to deq_*.
- Dequeue: deq_valid = (occupancy != 0). A fire (deq_valid & deq_ready) advances rd_ptr (wraps at DEPTH).
- deq_bits is held stable while deq_valid=1 and deq_ready=0.
- Occupancy:
  - +1 on accept without fire.
  - -1 on fire without accept.
  - Unchanged when both happen in the same cycle, including when full.
- Full/empty: full = (occupancy == DEPTH); wo_insns_ready = ~full, registered from the updated occupancy.
- Empty with fire impossible: deq_ready while empty is ignored.
- Pointer wrap: pointers are log2(DEPTH) bits and occupancy is tracked separately, so wrap is transparent. Entry order is strictly FIFO.
- Reset mid-operation: all entries are discarded immediately (asynchronous) and deq_valid drops to 0 without waiting for a clock. Counters clear.
- Upper bits 31:1 of wire-in 0x03 are ignored.

Test Plan:
- Single instruction: bits_0=0x01, bits_1=0x80, valid 0->1 with deq_ready=0.
  - -> deq_valid=1 one cycle after the edge; deq_bits=0x0000_0080_0000_0001; enq_count=1; occupancy=1.
- Level hold: valid held at 1 for 20 cycles, then 0.
  - -> exactly one enqueue (enq_count=1).
  - A following 0->1 -> enq_count=2.
- Fill and drop: DEPTH=4, deq_ready=0, 6 edges with bits_0=1..6.
  - -> occupancy=4, wo_insns_ready=0, drop_count=2.
  - Then deq_ready=1 -> heads dequeue as 1,2,3,4 in order.
- Full pass-through: FIFO full, an edge with bits_0=0x55 in the same cycle as a fire.
  - -> accepted; occupancy stays 4; drop_count unchanged; 0x55 emerges last.
- Reset behaviour:
  - Async reset asserted mid-clock with 3 entries -> deq_valid=0 and occupancy=0 before the next edge.
  - wi_valid held 1 through reset release -> no enqueue until a 0->1 transition.
- Wrap and saturation: stream 1000 instructions with deq_ready=1 -> enq_count=1000, data in order, no drops.
  - Force 70000 drops (CNT_W=16) -> drop_count=0xFFFF.

Source files
------------

// File: rtl/host_insn_bridge.sv
// host_insn_bridge: turns the host's level-style instruction handshake into
// single enqueue events. It joins the two 32-bit wire-ins into one 64-bit
// instruction, buffers it in a small FIFO and presents it to the core as a
// ready/valid stream.
//
// Ports:
//   clock, reset      design clock; asynchronous active-high reset
//   wi_bits_0/1       instruction low/high word (wire-ins 0x04/0x05)
//   wi_valid          host valid level (bit 0 of wire-in 0x03)
//   wo_insns_ready    1 while the FIFO is not full (wire-out 0x20)
//   deq_valid/ready   decoupled stream toward the core
//   deq_bits          {wi_bits_1, wi_bits_0} of the head entry
//   occupancy         current entry count
//   enq_count         accepted instructions, wraps
//   drop_count        edges rejected while full, saturates
module host_insn_bridge #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [31:0]              wi_bits_0,
  input  logic [31:0]              wi_bits_1,
  input  logic                     wi_valid,
  output logic                     wo_insns_ready,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [63:0]              deq_bits,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         enq_count,
  output logic [CNT_W-1:0]         drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]       OccFull = (AW + 1)'(DEPTH);
  localparam logic [AW:0]       OccOne  = (AW + 1)'(1);
  localparam logic [AW-1:0]     PtrOne  = AW'(1);
  localparam logic [CNT_W-1:0]  CntOne  = CNT_W'(1);

  logic [63:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      occ_q, occ_d;
  logic [CNT_W-1:0] enq_q, enq_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             valid_q;
  logic             ready_q, ready_d;

  logic rise, full, fire, accept;

  always_comb begin
    rise   = wi_valid & ~valid_q;
    full   = (occ_q == OccFull);
    fire   = deq_valid & deq_ready;
    // A fire in the same cycle frees the slot, so a full FIFO still accepts.
    accept = rise & (~full | fire);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    enq_d    = enq_q;
    drop_d   = drop_q;

    if (accept) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
      enq_d    = enq_q + CntOne;
    end else if (rise && (drop_q != '1)) begin
      drop_d = drop_q + CntOne;
    end

    if (fire) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end

    unique case ({accept, fire})
      2'b10:   occ_d = occ_q + OccOne;
      2'b01:   occ_d = occ_q - OccOne;
      default: occ_d = occ_q;
    endcase

    ready_d = (occ_d != OccFull);
  end

  // valid_q resets high so a level held through reset is not seen as an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      enq_q    <= '0;
      drop_q   <= '0;
      ready_q  <= 1'b1;
    end else begin
      valid_q  <= wi_valid;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      enq_q    <= enq_d;
      drop_q   <= drop_d;
      ready_q  <= ready_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define which entries are live.
  always_ff @(posedge clock) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= {wi_bits_1, wi_bits_0};
    end
  end

  assign deq_valid      = (occ_q != '0);
  assign deq_bits       = mem_q[rd_ptr_q];
  assign occupancy      = occ_q;
  assign wo_insns_ready = ready_q;
  assign enq_count      = enq_q;
  assign drop_count     = drop_q;

endmodule
